// File: rtl/instr_mem_responder_pkg.sv
// Shared constants for the instruction-fetch responder and its line array.
// The index width is also used by the fetch stage's performance counters.
package instr_mem_responder_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int ICACHE_INDEX_W = 6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MISS = 1'b1;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

endpackage

// File: rtl/instr_mem_responder_line_array.sv
// Direct-mapped tag/data/valid storage: one async read port, one write port,
// and a flush-all that wins over a same-cycle write.
module icache_line_array
    import instr_mem_responder_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = DEF_ADDR_W - ICACHE_INDEX_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);
    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    logic wr_commit;
    assign wr_commit = wr_en && !flush;

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_commit) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data are storage only; they are written with the valid bit.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: direct-mapped one-word-per-line cache in front
// of a multi-cycle backing read port. Hits answer in one cycle.
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [ADDR_W-1:0] iInstrMemAddress,
    input  logic              iInstrMemValid,
    output logic [DATA_W-1:0] oInstrMemData,
    output logic              oInstrMemReady,
    input  logic              iFlush,
    output logic              oMemReq,
    output logic [ADDR_W-1:0] oMemAddr,
    input  logic              iMemAck,
    input  logic [DATA_W-1:0] iMemData,
    output logic              oMiss
);
    localparam int TAG_W = tag_width(ADDR_W, INDEX_W);

    logic [0:0]        state;
    logic [ADDR_W-1:0] req_addr;
    logic              flush_pend;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              fill_en;

    // A request that coincides with a flush must not hit a line being cleared.
    assign hit = rd_valid && (rd_tag == iInstrMemAddress[ADDR_W-1:INDEX_W]) && !iFlush;

    assign fill_en = (state == ST_MISS) && iMemAck && !flush_pend;

    icache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk      (iClk),
        .rst      (iRst),
        .flush    (iFlush),
        .rd_index (iInstrMemAddress[INDEX_W-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_en),
        .wr_index (req_addr[INDEX_W-1:0]),
        .wr_tag   (req_addr[ADDR_W-1:INDEX_W]),
        .wr_data  (iMemData)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state          <= ST_IDLE;
            req_addr       <= '0;
            flush_pend     <= 1'b0;
            oInstrMemData  <= '0;
            oInstrMemReady <= 1'b0;
            oMemReq        <= 1'b0;
            oMemAddr       <= '0;
            oMiss          <= 1'b0;
        end else begin
            oInstrMemReady <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iInstrMemValid) begin
                        req_addr <= iInstrMemAddress;
                        if (hit) begin
                            oInstrMemData  <= rd_data;
                            oInstrMemReady <= 1'b1;
                        end else begin
                            oMemReq    <= 1'b1;
                            oMemAddr   <= iInstrMemAddress;
                            oMiss      <= 1'b1;
                            flush_pend <= 1'b0;
                            state      <= ST_MISS;
                        end
                    end
                end
                default: begin
                    // A flush seen at any point of the miss blocks the install.
                    if (iFlush) begin
                        flush_pend <= 1'b1;
                    end
                    if (iMemAck) begin
                        oInstrMemData  <= iMemData;
                        oInstrMemReady <= 1'b1;
                        oMemReq        <= 1'b0;
                        oMiss          <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: inputs change 1ns after each rising
// edge and outputs are checked there, the bench playing the backing memory.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        valid = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        miss;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    instr_mem_responder dut (
        .iClk             (clk),
        .iRst             (rst),
        .iInstrMemAddress (addr),
        .iInstrMemValid   (valid),
        .oInstrMemData    (rdata),
        .oInstrMemReady   (ready),
        .iFlush           (flush),
        .oMemReq          (mem_req),
        .oMemAddr         (mem_addr),
        .iMemAck          (mem_ack),
        .iMemData         (mem_data),
        .oMiss            (miss)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // Issue a request expected to miss, ack it after lat cycles, check the response.
    task automatic miss_fill(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input int lat);
        addr = a; valid = 1'b1;
        tick();
        chk1({tag, "_req"}, mem_req, 1'b1);
        chk({tag, "_addr"}, mem_addr, a);
        chk1({tag, "_miss"}, miss, 1'b1);
        chk1({tag, "_noready"}, ready, 1'b0);
        addr = a ^ 32'h0000_0077;
        for (int i = 1; i < lat; i++) begin
            tick();
            chk1({tag, "_hold_req"}, mem_req, 1'b1);
            chk({tag, "_hold_addr"}, mem_addr, a);
            chk1({tag, "_hold_miss"}, miss, 1'b1);
        end
        valid = 1'b0; mem_ack = 1'b1; mem_data = d;
        tick();
        mem_ack = 1'b0; mem_data = '0;
        chk1({tag, "_rdy"}, ready, 1'b1);
        chk({tag, "_data"}, rdata, d);
        chk1({tag, "_req_drop"}, mem_req, 1'b0);
        chk1({tag, "_miss_drop"}, miss, 1'b0);
    endtask

    task automatic hit(input string tag, input logic [31:0] a, input logic [31:0] d);
        addr = a; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk1({tag, "_rdy"}, ready, 1'b1);
        chk({tag, "_data"}, rdata, d);
        chk1({tag, "_noreq"}, mem_req, 1'b0);
    endtask

    initial begin
        tick();
        tick();
        chk1("rst_ready", ready, 1'b0);
        chk("rst_data", rdata, 32'h0);
        chk1("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk1("rst_miss", miss, 1'b0);
        rst = 1'b0;
        tick();

        miss_fill("m10", 32'h10, 32'hDEAD_BEEF, 3);
        tick();
        chk1("ready_pulse_once", ready, 1'b0);
        chk("data_holds", rdata, 32'hDEAD_BEEF);

        hit("h10", 32'h10, 32'hDEAD_BEEF);

        // Ack while idle must not produce a response.
        mem_ack = 1'b1; mem_data = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        chk1("idle_ack_ignored", ready, 1'b0);
        chk("idle_ack_data", rdata, 32'hDEAD_BEEF);

        miss_fill("m50", 32'h50, 32'hCAFE_0050, 2);
        miss_fill("m10_again", 32'h10, 32'hDEAD_BEEF, 1);
        hit("h10_refilled", 32'h10, 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++)
            miss_fill("pre", 32'h20 + i, 32'hA000_0020 + i, 1);
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h20 + i;
            tick();
            chk1("stream_rdy", ready, 1'b1);
            chk("stream_data", rdata, 32'hA000_0020 + i);
            chk1("stream_noreq", mem_req, 1'b0);
        end
        valid = 1'b0;
        tick();
        chk1("stream_end", ready, 1'b0);

        // Flush mid-miss: fetch still gets the word, the line stays invalid.
        addr = 32'h30; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk1("f30_req", mem_req, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("f30_still_miss", miss, 1'b1);
        mem_ack = 1'b1; mem_data = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        chk1("f30_rdy", ready, 1'b1);
        chk("f30_data", rdata, 32'h1234_5678);
        miss_fill("f30_refetch", 32'h30, 32'h1234_5678, 1);
        miss_fill("m20_flushed", 32'h20, 32'hA000_0020, 1);

        // Request coinciding with a flush on a valid line is a miss.
        hit("h20", 32'h20, 32'hA000_0020);
        flush = 1'b1;
        miss_fill("m20_flush_req", 32'h20, 32'hB000_0020, 1);
        flush = 1'b0;

        // Reset two cycles into a miss returns outputs without a clock edge.
        addr = 32'h90; valid = 1'b1;
        tick();
        valid = 1'b0;
        chk1("r90_req", mem_req, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk1("async_rst_req", mem_req, 1'b0);
        chk1("async_rst_miss", miss, 1'b0);
        chk1("async_rst_ready", ready, 1'b0);
        chk("async_rst_data", rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        miss_fill("m10_post_rst", 32'h10, 32'hDEAD_BEEF, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Responder end of the instruction-fetch memory interface. Accepts the fetch stage's address/valid request and returns an instruction word plus a ready pulse.
- Implemented as a direct-mapped, one-word-per-line instruction cache in front of a multi-cycle backing memory read port.
- Sits between the fetch stage and the memory arbiter.
- Hits answer in one cycle; misses fetch from backing memory, fill the line, then answer.

Parameters:
- ADDR_W, 32, word-address width; matches the fetch PC width.
- INDEX_W, 6, cache index bits; LINES = 2**INDEX_W = 64.
- DATA_W, 32, instruction width.

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iInstrMemAddress  input  ADDR_W  word address from fetch.
- iInstrMemValid  input  1  fetch request valid.
- oInstrMemData  output  DATA_W  instruction returned to fetch.
- oInstrMemReady  output  1  one-cycle pulse; oInstrMemData is valid for this address.
- iFlush  input  1  invalidate all lines; used by self-modifying code and loaders.
- oMemReq  output  1  backing read request.
- oMemAddr  output  ADDR_W  backing read word address.
- iMemAck  input  1  backing read data valid; acknowledges oMemReq.
- iMemData  input  DATA_W  backing read data.
- oMiss  output  1  high while a miss is outstanding; performance/debug.

Behaviour:
- Reset (async, iRst=1):
  - state=IDLE; all valid bits cleared.
  - oInstrMemReady=0, oInstrMemData=0, oMemReq=0, oMemAddr=0, oMiss=0.
  - Tag/data arrays are not reset.
- Address split: index = addr[INDEX_W-1:0]; tag = addr[ADDR_W-1:INDEX_W]. Tag width = ADDR_W-INDEX_W.
- Outputs oInstrMemData, oInstrMemReady, oMemReq and oMemAddr are all registered.
- State IDLE:
  - If iInstrMemValid=1 at a clock edge, capture the address into reqAddr and look up the line.
  - Hit (valid && tag match): at that edge, load oInstrMemData with the line data and set oInstrMemReady=1. Latency is 1 cycle; stay in IDLE.
  - Back-to-back hits: a request sampled in the same cycle that ready is high is serviced normally, giving one word per cycle.
  - Miss: at that edge, set oMemReq=1, oMemAddr=captured address, oMiss=1; go to MISS.
- State MISS:
  - Hold oMemReq and oMemAddr stable until iMemAck=1.
  - On ack, write data/tag/valid for reqAddr's index, unless the install is suppressed by a flush (see Flush below).
  - In the same edge: oInstrMemData=iMemData, oInstrMemReady=1, oMemReq=0, oMiss=0; return to IDLE.
  - The miss penalty is therefore 1 cycle plus the backing latency.
  - iMemAck is honoured only in MISS; ack in IDLE is ignored.
- oInstrMemReady:
  - Is high for exactly one cycle per serviced request, then drops to 0.
  - oInstrMemData holds its last value until the next response.
- Address changes while not idle:
  - Changes to iInstrMemAddress or iInstrMemValid during MISS are ignored.
  - The captured address is always the one answered.
  - Fetch re-presents its address after ready, and that is a new request.
- Flush:
  - iFlush=1 clears every valid bit at the next edge, with priority over a same-cycle fill.
  - A flush during MISS still completes the response to fetch, but the line is not installed.
  - A request coinciding with a flush in IDLE is treated as a miss.
- A second request cannot be accepted while in MISS; there is no queueing.
- Reset asserted mid-miss: state and outputs return to reset values immediately, and oMemReq drops asynchronously. The backing memory must tolerate an abandoned request.
- A cache write never partially updates a line; data, tag and valid are written together.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, MISS=1'b1);
  - default ADDR_W and DATA_W;
  - the ICACHE_INDEX_W constant, shared with the fetch stage's performance counters.
- Sub-module icache_line_array: tag/data/valid storage with one read port and one write port, plus a flush-all input. The FSM and output registers stay in the top level.

Test Plan:
- Reset, then request addr 0x00000010 with backing data 0xDEADBEEF and ack after 3 cycles:
  - oMemReq=1, oMemAddr=0x10;
  - ready pulse with data 0xDEADBEEF one edge after ack;
  - oMiss was high throughout.
- Repeat request 0x10 -> ready on the next edge with data 0xDEADBEEF and no oMemReq (hit, 1-cycle).
- Conflict: request 0x10 then 0x50, which has the same index 0x10 and a different tag:
  - 0x50 misses;
  - re-request 0x10 misses again and refetches.
- Stream 0x20..0x23 with all lines pre-filled, valid held high -> 4 consecutive ready pulses with the correct data.
- Flush during a miss on 0x30, then ack with 0x12345678:
  - fetch receives 0x12345678;
  - the following request to 0x30 misses (line not installed).
- Assert iRst two cycles into a miss -> oMemReq, oMiss and oInstrMemReady go to 0 immediately; a subsequent request to 0x10 misses.
